// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// memory-stall hold and stall-deferred flush. Supplies the IdEx* register
// fields and controls consumed by the EX-stage forwarding unit.
//
// Flow control: the stage has no valid/ready pair of its own. IdExValid
// qualifies every IdEx* output. MemStall freezes all state, including the
// bubble counter. LoadUseStall tells the front end (PC, IF/ID) to hold the
// same ID instruction for one more cycle. It is combinational from the
// registered state and the current ID fields.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int AOP_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemStall,
  input  logic              Flush,
  input  logic              IdValid,
  input  logic [4:0]        IdRs,
  input  logic [4:0]        IdRt,
  input  logic [4:0]        IdRd,
  input  logic              IdUsesRt,
  input  logic [DATA_W-1:0] IdRsData,
  input  logic [DATA_W-1:0] IdRtData,
  input  logic [DATA_W-1:0] IdImm,
  input  logic              IdRegW,
  input  logic              IdMemRead,
  input  logic              IdMemWrite,
  input  logic              IdMemToReg,
  input  logic              IdAluSrc,
  input  logic              IdRegDst,
  input  logic [AOP_W-1:0]  IdAluOp,
  output logic              IdExValid,
  output logic [4:0]        IdExRs,
  output logic [4:0]        IdExRt,
  output logic [4:0]        IdExRd,
  output logic [DATA_W-1:0] IdExRsData,
  output logic [DATA_W-1:0] IdExRtData,
  output logic [DATA_W-1:0] IdExImm,
  output logic              IdExRegW,
  output logic              IdExMemRead,
  output logic              IdExMemWrite,
  output logic              IdExMemToReg,
  output logic              IdExAluSrc,
  output logic              IdExRegDst,
  output logic [AOP_W-1:0]  IdExAluOp,
  output logic              LoadUseStall,
  output logic [CNT_W-1:0]  BubbleCnt,
  // Debug view of the deferred-flush state bit
  output logic              FlushPending
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic haz;
  logic insertBubble;

  // Load-use hazard: a valid load in EX whose destination a real ID instruction reads
  always_comb begin
    haz = IdExValid & IdExMemRead & (IdExRt != 5'd0) &
          ((IdExRt == IdRs) | (IdUsesRt & (IdExRt == IdRt))) & IdValid;
    // A flush squashes the ID instruction, so there is nothing to stall for
    LoadUseStall = haz & ~Flush & ~FlushPending;
    insertBubble = ~MemStall & (Flush | FlushPending | LoadUseStall);
  end

  // Remember a flush that arrived while the stage was frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FlushPending <= 1'b0;
    end else if (MemStall) begin
      if (Flush) FlushPending <= 1'b1;
    end else begin
      FlushPending <= 1'b0;
    end
  end

  // Pipeline register: hold on stall, zero on bubble, else capture ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IdExValid    <= 1'b0;
      IdExRs       <= '0;
      IdExRt       <= '0;
      IdExRd       <= '0;
      IdExRsData   <= '0;
      IdExRtData   <= '0;
      IdExImm      <= '0;
      IdExRegW     <= 1'b0;
      IdExMemRead  <= 1'b0;
      IdExMemWrite <= 1'b0;
      IdExMemToReg <= 1'b0;
      IdExAluSrc   <= 1'b0;
      IdExRegDst   <= 1'b0;
      IdExAluOp    <= '0;
    end else if (!MemStall) begin
      if (insertBubble) begin
        // Zeroed register fields cannot match in forwarding or hazard logic
        IdExValid    <= 1'b0;
        IdExRs       <= '0;
        IdExRt       <= '0;
        IdExRd       <= '0;
        IdExRsData   <= '0;
        IdExRtData   <= '0;
        IdExImm      <= '0;
        IdExRegW     <= 1'b0;
        IdExMemRead  <= 1'b0;
        IdExMemWrite <= 1'b0;
        IdExMemToReg <= 1'b0;
        IdExAluSrc   <= 1'b0;
        IdExRegDst   <= 1'b0;
        IdExAluOp    <= '0;
      end else begin
        IdExValid    <= IdValid;
        IdExRs       <= IdRs;
        IdExRt       <= IdRt;
        IdExRd       <= IdRd;
        IdExRsData   <= IdRsData;
        IdExRtData   <= IdRtData;
        IdExImm      <= IdImm;
        // An empty ID slot must never carry side-effecting controls
        IdExRegW     <= IdValid & IdRegW;
        IdExMemRead  <= IdValid & IdMemRead;
        IdExMemWrite <= IdValid & IdMemWrite;
        IdExMemToReg <= IdValid & IdMemToReg;
        IdExAluSrc   <= IdValid & IdAluSrc;
        IdExRegDst   <= IdValid & IdRegDst;
        IdExAluOp    <= IdValid ? IdAluOp : '0;
      end
    end
  end

  // Saturating count of inserted bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BubbleCnt <= '0;
    end else if (insertBubble && (BubbleCnt != CntMax)) begin
      BubbleCnt <= BubbleCnt + CntOne;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage with a behavioural model.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic          valid;
    logic [4:0]    rs, rt, rd;
    logic          usesRt;
    logic [DW-1:0] rsData, rtData, imm;
    logic          regW, memRead, memWrite, memToReg, aluSrc, regDst;
    logic [AW-1:0] aluOp;
    logic          memStall, flush;
  } stim_t;

  typedef struct packed {
    logic          valid;
    logic [4:0]    rs, rt, rd;
    logic [DW-1:0] rsData, rtData, imm;
    logic          regW, memRead, memWrite, memToReg, aluSrc, regDst;
    logic [AW-1:0] aluOp;
    logic          lus;
    logic          fp;
    logic [CW-1:0] cnt;
  } obs_t;

  localparam int OW = $bits(obs_t);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  stim_t s;
  obs_t  got;
  obs_t  m;          // model of the registered state
  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int pushes = 0;

  logic              oValid, oRegW, oMemRead, oMemWrite, oMemToReg, oAluSrc, oRegDst;
  logic [4:0]        oRs, oRt, oRd;
  logic [DW-1:0]     oRsData, oRtData, oImm;
  logic [AW-1:0]     oAluOp;
  logic              oLus, oFp;
  logic [CW-1:0]     oCnt;

  id_ex_stage #(.DATA_W(DW), .AOP_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .MemStall(s.memStall), .Flush(s.flush),
    .IdValid(s.valid), .IdRs(s.rs), .IdRt(s.rt), .IdRd(s.rd), .IdUsesRt(s.usesRt),
    .IdRsData(s.rsData), .IdRtData(s.rtData), .IdImm(s.imm),
    .IdRegW(s.regW), .IdMemRead(s.memRead), .IdMemWrite(s.memWrite),
    .IdMemToReg(s.memToReg), .IdAluSrc(s.aluSrc), .IdRegDst(s.regDst), .IdAluOp(s.aluOp),
    .IdExValid(oValid), .IdExRs(oRs), .IdExRt(oRt), .IdExRd(oRd),
    .IdExRsData(oRsData), .IdExRtData(oRtData), .IdExImm(oImm),
    .IdExRegW(oRegW), .IdExMemRead(oMemRead), .IdExMemWrite(oMemWrite),
    .IdExMemToReg(oMemToReg), .IdExAluSrc(oAluSrc), .IdExRegDst(oRegDst),
    .IdExAluOp(oAluOp), .LoadUseStall(oLus), .BubbleCnt(oCnt), .FlushPending(oFp)
  );

  assign got = '{valid: oValid, rs: oRs, rt: oRt, rd: oRd, rsData: oRsData, rtData: oRtData,
                 imm: oImm, regW: oRegW, memRead: oMemRead, memWrite: oMemWrite,
                 memToReg: oMemToReg, aluSrc: oAluSrc, regDst: oRegDst, aluOp: oAluOp,
                 lus: oLus, fp: oFp, cnt: oCnt};

  // clock
  always #5 clk = ~clk;

  // monitor: compare DUT outputs against the oldest expectation each cycle
  always begin
    logic [OW-1:0] e;
    @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got !== obs_t'(e)) begin
        failures++;
        $display("FAIL outputs t=%0t got=%h exp=%h", $time, got, e);
      end
    end
  end

  function automatic stim_t idle();
    stim_t st;
    st = '0;
    return st;
  endfunction

  // drive one cycle of inputs and advance the model across the next edge
  task automatic drive(input stim_t st);
    logic uses_load, lus;
    obs_t e;
    logic [CW-1:0] c;
    @(negedge clk);
    s = st;
    // ID reads a register that the load in EX has not yet produced
    uses_load = m.valid && m.memRead && m.rt != 0 && st.valid &&
                (m.rt == st.rs || (st.usesRt && m.rt == st.rt));
    lus = uses_load && !st.flush && !m.fp;
    e = m;
    e.lus = lus;
    exp_q.push_back(e);
    pushes++;
    if (st.memStall) begin
      if (st.flush) m.fp = 1'b1;
    end else if (st.flush || m.fp || lus) begin
      c = m.cnt;
      m = '0;
      m.cnt = (c == '1) ? c : c + 1'b1;
    end else begin
      m.valid = st.valid;
      m.rs = st.rs; m.rt = st.rt; m.rd = st.rd;
      m.rsData = st.rsData; m.rtData = st.rtData; m.imm = st.imm;
      m.regW = st.valid & st.regW;
      m.memRead = st.valid & st.memRead;
      m.memWrite = st.valid & st.memWrite;
      m.memToReg = st.valid & st.memToReg;
      m.aluSrc = st.valid & st.aluSrc;
      m.regDst = st.valid & st.regDst;
      m.aluOp = st.valid ? st.aluOp : '0;
      m.fp = 1'b0;
    end
  endtask

  // asynchronous reset between clock edges; outputs must clear at once
  task automatic async_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (got !== obs_t'(0)) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", got);
    end
    m = '0;
    s = idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic stim_t rand_stim();
    stim_t st;
    st.valid = ($urandom_range(0, 9) < 8);
    st.rs = 5'($urandom_range(0, 7));
    st.rt = 5'($urandom_range(0, 7));
    st.rd = 5'($urandom_range(0, 31));
    st.usesRt = 1'($urandom);
    st.rsData = $urandom; st.rtData = $urandom; st.imm = $urandom;
    st.regW = 1'($urandom); st.memRead = ($urandom_range(0, 2) == 0);
    st.memWrite = 1'($urandom); st.memToReg = 1'($urandom);
    st.aluSrc = 1'($urandom); st.regDst = 1'($urandom);
    st.aluOp = AW'($urandom);
    st.memStall = ($urandom_range(0, 9) < 2);
    st.flush = ($urandom_range(0, 19) < 3);
    return st;
  endfunction

  initial begin
    stim_t st;
    int wait_cnt;
    s = idle();
    m = '0;
    // reset state
    #12;
    checks++;
    if (got !== obs_t'(0)) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // normal flow
    st = idle(); st.valid = 1; st.rs = 3; st.rt = 4; st.rd = 5; st.regW = 1; st.rsData = 32'h11;
    drive(st);
    // load-use: lw rt=8 then add using rs=8 (held by IF/ID for one extra cycle)
    st = idle(); st.valid = 1; st.rt = 8; st.memRead = 1; st.regW = 1; st.memToReg = 1; st.aluSrc = 1;
    drive(st);
    st = idle(); st.valid = 1; st.rs = 8; st.rt = 9; st.rd = 10; st.usesRt = 1; st.regW = 1; st.regDst = 1;
    drive(st);
    drive(st);
    drive(idle());
    // zero register load, then unused Rt
    st = idle(); st.valid = 1; st.rt = 0; st.memRead = 1; drive(st);
    st = idle(); st.valid = 1; st.rs = 0; drive(st);
    st = idle(); st.valid = 1; st.rt = 8; st.memRead = 1; drive(st);
    st = idle(); st.valid = 1; st.rs = 1; st.rt = 8; st.usesRt = 0; drive(st);
    // flush during a 3-cycle memory stall
    st = idle(); st.valid = 1; st.rs = 2; st.imm = 32'hABCD; st.memStall = 1; st.flush = 1; drive(st);
    st.flush = 0; drive(st); drive(st);
    st.memStall = 0; drive(st);
    drive(st);
    // flush together with a hazard
    st = idle(); st.valid = 1; st.rt = 8; st.memRead = 1; drive(st);
    st = idle(); st.valid = 1; st.rs = 8; st.flush = 1; drive(st);
    // stall + flush + hazard: hold, then one bubble on release
    st = idle(); st.valid = 1; st.rt = 6; st.memRead = 1; drive(st);
    st = idle(); st.valid = 1; st.rs = 6; st.memStall = 1; st.flush = 1; drive(st);
    st.memStall = 0; st.flush = 0; drive(st);
    drive(idle());
    // counter saturation: five consecutive flush bubbles
    st = idle(); st.flush = 1;
    repeat (5) drive(st);
    drive(idle());
    drive(idle());
    async_reset();

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      drive(rand_stim());
    end
    drive(idle());
    drive(idle());

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register of the 5-stage MIPS core, directly upstream of the forwarding unit. It supplies the IdExRs/IdExRt/IdExRd fields and control that EX-stage forwarding compares against. It also performs load-use hazard detection and bubble insertion, and holds on a global memory stall. Flushes that arrive during a stall are retained until the stall ends.

Parameters:
DATA_W, 32, register/immediate datapath width
AOP_W, 4, ALU-op control width
CNT_W, 16, bubble performance-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
MemStall  in  1  global cache stall; holds the stage
Flush  in  1  squash the ID instruction (branch/jump resolved in EX)
IdValid  in  1  ID holds a real instruction
IdRs, IdRt, IdRd  in  5 each  decoded register fields
IdUsesRt  in  1  the ID instruction reads Rt as a source
IdRsData, IdRtData, IdImm  in  DATA_W each  register-file reads, sign-extended immediate
IdRegW, IdMemRead, IdMemWrite, IdMemToReg, IdAluSrc, IdRegDst  in  1 each  control
IdAluOp  in  AOP_W  ALU control
IdExValid  out  1  registered valid
IdExRs, IdExRt, IdExRd  out  5 each  registered fields, consumed by forwarding
IdExRsData, IdExRtData, IdExImm  out  DATA_W each
IdExRegW, IdExMemRead, IdExMemWrite, IdExMemToReg, IdExAluSrc, IdExRegDst  out  1 each
IdExAluOp  out  AOP_W
LoadUseStall  out  1  freeze the PC and IF/ID (combinational)
BubbleCnt  out  CNT_W  count of bubbles inserted, saturating

Behaviour:
- Reset: when rst_n is low, all outputs and FlushPending are 0 asynchronously.
- Hazard (combinational from registered state):
  - Haz = IdExValid & IdExMemRead & (IdExRt != 0) & ((IdExRt == IdRs) | (IdUsesRt & IdExRt == IdRt)) & IdValid.
  - LoadUseStall = Haz & ~Flush & ~FlushPending.
  - LoadUseStall stays asserted during MemStall.
- FlushPending register:
  - Set when Flush & MemStall.
  - Cleared on the first edge where MemStall = 0.
- Per-edge update, highest priority first:
  1. MemStall = 1: every register holds. A Flush arriving now is captured only in FlushPending.
  2. Flush | FlushPending: insert a bubble.
  3. LoadUseStall: insert a bubble.
  4. Otherwise: load all Id* inputs, with IdExValid <= IdValid.
- Bubble: IdExValid, all 1-bit controls, IdExAluOp, IdExRs, IdExRt and IdExRd all become 0. Zeroed register fields guarantee no spurious forward match or hazard. Data fields become 0.
- Invalid load: if IdValid = 0 on a normal load, the controls are loaded as 0 regardless of the inputs.
- Latency: one cycle from ID inputs to IdEx* outputs. A load-use hazard costs exactly one bubble, because the hazard clears once the load moves on to MEM.
- BubbleCnt: increments by 1 on each edge that inserts a bubble (cases 2 and 3). It holds at 2^CNT_W-1 once saturated and does not change during MemStall.
- Simultaneous events:
  - Flush + hazard: Flush wins, a single bubble is inserted and LoadUseStall = 0.
  - MemStall + Flush + hazard: hold, FlushPending set, then one bubble on release.
- Reset mid-stall: outputs are cleared and FlushPending is lost, as intended.

Test Plan:
- Reset/normal flow: rst_n low, then one edge loading IdRs=3, IdRt=4, IdRd=5, IdRegW=1, IdRsData=0x11 -> IdExRs=3, IdExRt=4, IdExRd=5, IdExRegW=1, IdExRsData=0x11, LoadUseStall=0.
- Load-use: IdEx holds lw with IdExRt=8; ID is add with IdRs=8 -> LoadUseStall=1. Next edge is a bubble (IdExValid=0, IdExRt=0, controls 0) and BubbleCnt=1. The following edge loads the add, and LoadUseStall=0.
- Zero register and unused Rt: IdExRt=0 load with IdRs=0 -> no stall. IdExRt=8 with IdRt=8 and IdUsesRt=0 -> no stall.
- Flush during MemStall: MemStall=1 for 3 cycles with Flush pulsed in cycle 1 -> outputs held for 3 cycles. The first edge after release inserts a bubble, FlushPending=0, BubbleCnt=+1.
- Flush + hazard together: Flush=1 while Haz is true -> LoadUseStall=0, one bubble, BubbleCnt=+1 (not +2).
- Counter saturation with CNT_W=2: 5 consecutive bubbles -> BubbleCnt=3 and holds. Async reset mid-operation -> all outputs 0 immediately, without waiting for clk.
